mips_fetch_unit: RTL

- Instruction-fetch stage that feeds the main decoder; the decoder's OpCode/Funct come from inst[31:26]/inst[5:0].
- Holds the PC and fetches from instruction memory through a req/ready handshake. It latches the instruction and holds it stable until the datapath signals retirement.
- On retirement it computes the next PC from the decoder's PCSrc/Branch, the ALU Zero flag and the rs register value.

---
 rtl/mips_fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: two-state (FETCH/EXEC) MIPS instruction fetch with PC sequencing.
// Define MIPS_FETCH_ADDR_ERR_EN to trap misaligned jr/jalr targets to EXC_VECTOR and pulse addr_err.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic        addr_err
);
  typedef enum logic {FETCH, EXEC} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] br_off, next_pc, target;
  logic        retire;
  assign pc_plus4   = pc_q + 32'd4;
  assign br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign retire     = (state_q == EXEC) && exec_done;
  assign imem_req   = (state_q == FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  // Reserved PCSrc=01 falls through to sequential like an untaken branch.
  always_comb begin
    next_pc = pc_plus4;
    next_pc = (PCSrc == 2'b00 && Branch && Zero) ? pc_plus4 + br_off :
              (PCSrc == 2'b10) ? {pc_plus4[31:28], inst_q[25:0], 2'b00} :
              (PCSrc == 2'b11) ? {jr_target[31:2], 2'b00} : pc_plus4;
  end
`ifdef MIPS_FETCH_ADDR_ERR_EN
  logic misaligned, addr_err_q, addr_err_d;
  assign misaligned = (PCSrc == 2'b11) && (jr_target[1:0] != 2'b00);
  assign target     = misaligned ? EXC_VECTOR : next_pc;
  assign addr_err_d = retire && misaligned;
  assign addr_err   = addr_err_q;
  always_ff @(posedge clk) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{EXC_VECTOR, jr_target[1:0]};
  assign target    = next_pc;
  assign addr_err  = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    if (state_q == FETCH) begin
      if (imem_ready) begin
        inst_d       = imem_rdata;
        inst_valid_d = 1'b1;
        state_d      = EXEC;
      end
    end else if (retire) begin
      pc_d         = target;
      inst_valid_d = 1'b0;
      state_d      = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end
endmodule
